reg_wr_arbiter: RTL

REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

---
 rtl/reg_wr_arbiter_pkg.sv | 24 ++
 rtl/reg_wr_arbiter_rr_pick.sv | 35 +++
 rtl/reg_wr_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/reg_wr_arbiter_pkg.sv
// rtl/reg_wr_arbiter_pkg.sv - shared types and constants for the register-write arbiter
package reg_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  localparam int N_REQ_DEFAULT   = 6;
  localparam int TIMEOUT_DEFAULT = 255;

  localparam int REQ_SPI     = 0;
  localparam int REQ_TTEHASH = 1;
  localparam int REQ_PORT0   = 2;
  localparam int REQ_PORT1   = 3;
  localparam int REQ_PORT2   = 4;
  localparam int REQ_PORT3   = 5;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_wr_arbiter_rr_pick.sv
// rtl/reg_wr_arbiter_rr_pick.sv - combinational round-robin picker
// Returns the first set req bit searching upward from last_grant+1 with wrap.
module rr_pick
  import reg_wr_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  localparam int IW   = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [IW-1:0]    grant,
  output logic             valid
);

  int          idx;
  logic [IW-1:0] idx_w;

  // Walk from the farthest offset back to the nearest so the nearest hit wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(last_grant) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_w = IW'(idx);
      if (req[idx_w]) begin
        grant = idx_w;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_wr_arbiter.sv
// rtl/reg_wr_arbiter.sv - round-robin arbiter for 4-phase register-write requesters
// Grants one requester at a time, issues a one-cycle write strobe, then waits for req release.
module reg_wr_arbiter
  import reg_wr_arbiter_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  output logic [N_REQ-1:0]    ack,
  input  logic [7*N_REQ-1:0]  addr_in,
  input  logic [16*N_REQ-1:0] din_in,
  output logic                wr,
  output logic [6:0]          addr,
  output logic [15:0]         din,
  output logic                busy,
  output logic                timeout_err,
  output logic [15:0]         wr_count
);

  localparam int IW = idx_width(N_REQ);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_t    state;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic [CW-1:0] hold_cnt;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .grant      (pick_idx),
    .valid      (pick_valid)
  );

  // last_grant doubles as the index of the requester currently being served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ack         <= '0;
      wr          <= 1'b0;
      addr        <= '0;
      din         <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      wr_count    <= '0;
      hold_cnt    <= '0;
      last_grant  <= IW'(N_REQ - 1);
    end else begin
      wr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state      <= ST_WRITE;
            busy       <= 1'b1;
            wr         <= 1'b1;
            ack        <= N_REQ'(1) << pick_idx;
            addr       <= addr_in[7*pick_idx +: 7];
            din        <= din_in[16*pick_idx +: 16];
            last_grant <= pick_idx;
            wr_count   <= wr_count + 16'd1;
          end
        end
        ST_WRITE: begin
          state    <= ST_RELEASE;
          hold_cnt <= '0;
        end
        ST_RELEASE: begin
          if (!req[last_grant]) begin
            ack   <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (hold_cnt == CNT_LAST) begin
            ack         <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          ack   <= '0;
        end
      endcase
    end
  end

endmodule
